// File: rtl/adc_frame_buffer_pkg.sv
// Shared types and widths for the ADC frame buffer: sample/channel widths and
// the writer/reader state encodings.
package adc_frame_buffer_pkg;

    localparam int SAMPLE_W = 10;
    localparam int CHAN_W   = 4;
    localparam int NUM_BANKS = 2;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_FILL  = 2'd1,
        W_STALL = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_HOLD  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port frame storage: one write port, one registered read port.
// Address is {bank, index}; read data appears one cycle after rd_en.
module frame_bank_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adc_frame_buffer.sv
// Captures samples of one ADC channel into ping-pong frame banks and streams
// each completed frame to the FFT stage over a valid/ready handshake.
module adc_frame_buffer
    import adc_frame_buffer_pkg::*;
#(
    parameter int FRAME_LEN = 256,
    parameter int ADDR_W    = 8,
    parameter int DROP_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [CHAN_W-1:0]   cfg_channel,
    output logic [CHAN_W-1:0]   adc_channel,
    input  logic                new_sample,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [CHAN_W-1:0]   sample_channel,
    output logic [SAMPLE_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic [CHAN_W-1:0]   out_channel,
    output logic [DROP_W-1:0]   drop_count
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    wr_state_t          wr_state_reg, wr_state_next;
    logic               wr_bank_reg, wr_bank_next;
    logic [ADDR_W-1:0]  wr_idx_reg, wr_idx_next;
    logic [CHAN_W-1:0]  adc_channel_reg, adc_channel_next;
    logic [DROP_W-1:0]  drop_count_reg, drop_count_next;

    rd_state_t          rd_state_reg, rd_state_next;
    logic               rd_bank_reg, rd_bank_next;
    logic [ADDR_W-1:0]  rd_idx_reg, rd_idx_next;

    logic [NUM_BANKS-1:0] bank_full;
    logic [NUM_BANKS-1:0] bank_busy;
    logic [CHAN_W-1:0]    bank_chan [NUM_BANKS];

    logic               frame_done;
    logic               bank_clr;
    logic               ram_wr_en;
    logic               ram_rd_en;
    logic [SAMPLE_W-1:0] ram_rd_data;
    logic               sample_match;

    assign sample_match = new_sample && (sample_channel == adc_channel_reg);

    // Per-bank full flag and channel tag. bank_busy treats a bank being freed
    // this cycle as already empty, so a completing writer never stalls on it.
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic              full_reg;
        logic [CHAN_W-1:0] chan_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                full_reg <= 1'b0;
                chan_reg <= '0;
            end else if (frame_done && (wr_bank_reg == 1'(gi))) begin
                full_reg <= 1'b1;
                chan_reg <= adc_channel_reg;
            end else if (bank_clr && (rd_bank_reg == 1'(gi))) begin
                full_reg <= 1'b0;
            end
        end

        assign bank_full[gi] = full_reg;
        assign bank_chan[gi] = chan_reg;
        assign bank_busy[gi] = full_reg && !(bank_clr && (rd_bank_reg == 1'(gi)));
    end

    frame_bank_ram #(
        .ADDR_W (ADDR_W + 1),
        .DATA_W (SAMPLE_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr ({wr_bank_reg, wr_idx_reg}),
        .wr_data (sample),
        .rd_en   (ram_rd_en),
        .rd_addr ({rd_bank_reg, rd_idx_reg}),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_reg    <= W_IDLE;
            wr_bank_reg     <= 1'b0;
            wr_idx_reg      <= '0;
            adc_channel_reg <= '0;
            drop_count_reg  <= '0;
        end else begin
            wr_state_reg    <= wr_state_next;
            wr_bank_reg     <= wr_bank_next;
            wr_idx_reg      <= wr_idx_next;
            adc_channel_reg <= adc_channel_next;
            drop_count_reg  <= drop_count_next;
        end
    end

    always_comb begin
        wr_state_next    = wr_state_reg;
        wr_bank_next     = wr_bank_reg;
        wr_idx_next      = wr_idx_reg;
        adc_channel_next = adc_channel_reg;
        drop_count_next  = drop_count_reg;
        ram_wr_en        = 1'b0;
        frame_done       = 1'b0;

        case (wr_state_reg)
            W_IDLE: begin
                if (enable) begin
                    adc_channel_next = cfg_channel;
                    wr_idx_next      = '0;
                    // Re-enabling onto a bank still awaiting readout must wait.
                    if (bank_busy[wr_bank_reg]) begin
                        wr_state_next = W_STALL;
                    end else begin
                        wr_state_next = W_FILL;
                        if (new_sample && (sample_channel == cfg_channel)) begin
                            ram_wr_en   = 1'b1;
                            wr_idx_next = wr_idx_reg + 1'b1;
                        end
                    end
                end
            end

            W_FILL: begin
                if (!enable) begin
                    wr_state_next = W_IDLE;
                    wr_idx_next   = '0;
                end else if (sample_match) begin
                    ram_wr_en = 1'b1;
                    if (wr_idx_reg == LAST_IDX) begin
                        frame_done       = 1'b1;
                        wr_bank_next     = ~wr_bank_reg;
                        wr_idx_next      = '0;
                        adc_channel_next = cfg_channel;
                        if (bank_busy[~wr_bank_reg]) begin
                            wr_state_next = W_STALL;
                        end
                    end else begin
                        wr_idx_next = wr_idx_reg + 1'b1;
                    end
                end
            end

            W_STALL: begin
                if (!enable) begin
                    wr_state_next = W_IDLE;
                    wr_idx_next   = '0;
                end else begin
                    if (sample_match && (drop_count_reg != '1)) begin
                        drop_count_next = drop_count_reg + 1'b1;
                    end
                    if (!bank_busy[wr_bank_reg]) begin
                        wr_state_next = W_FILL;
                        wr_idx_next   = '0;
                    end
                end
            end

            default: begin
                wr_state_next = W_IDLE;
                wr_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_reg <= R_IDLE;
            rd_bank_reg  <= 1'b0;
            rd_idx_reg   <= '0;
        end else begin
            rd_state_reg <= rd_state_next;
            rd_bank_reg  <= rd_bank_next;
            rd_idx_reg   <= rd_idx_next;
        end
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        rd_bank_next  = rd_bank_reg;
        rd_idx_next   = rd_idx_reg;
        ram_rd_en     = 1'b0;
        bank_clr      = 1'b0;

        case (rd_state_reg)
            R_IDLE: begin
                if (bank_full[rd_bank_reg]) begin
                    rd_state_next = R_FETCH;
                end
            end

            R_FETCH: begin
                ram_rd_en     = 1'b1;
                rd_state_next = R_HOLD;
            end

            R_HOLD: begin
                if (out_ready) begin
                    if (rd_idx_reg == LAST_IDX) begin
                        bank_clr      = 1'b1;
                        rd_bank_next  = ~rd_bank_reg;
                        rd_idx_next   = '0;
                        rd_state_next = R_IDLE;
                    end else begin
                        rd_idx_next   = rd_idx_reg + 1'b1;
                        rd_state_next = R_FETCH;
                    end
                end
            end

            default: begin
                rd_state_next = R_IDLE;
            end
        endcase
    end

    // The RAM read register has no reset, so outputs are gated by out_valid.
    assign out_valid   = (rd_state_reg == R_HOLD);
    assign out_data    = out_valid ? ram_rd_data : '0;
    assign out_last    = out_valid && (rd_idx_reg == LAST_IDX);
    assign out_channel = out_valid ? bank_chan[rd_bank_reg] : '0;
    assign adc_channel = adc_channel_reg;
    assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Randomized scoreboard bench for adc_frame_buffer: a frame-level reference
// model queues expected words; a monitor pops and compares on each handshake.
module tb_adc_frame_buffer;

    localparam int FRAME_LEN = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] cfg_channel = '0;
    logic       new_sample = 1'b0;
    logic [9:0] sample = '0;
    logic [3:0] sample_channel = '0;
    logic       out_ready = 1'b0;
    logic [3:0] adc_channel;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic [3:0] out_channel;
    logic [15:0] drop_count;

    adc_frame_buffer #(.FRAME_LEN(256), .ADDR_W(8), .DROP_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .cfg_channel    (cfg_channel),
        .adc_channel    (adc_channel),
        .new_sample     (new_sample),
        .sample         (sample),
        .sample_channel (sample_channel),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .out_channel    (out_channel),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] data;
        logic       last;
        logic [3:0] chan;
    } word_t;

    word_t exp_q[$];
    int    checks = 0;
    int    passed = 0;

    // Reference model: frame-level view of capture and bank occupancy.
    bit         m_active = 0;
    bit         m_stalled = 0;
    logic [3:0] m_chan = '0;
    logic [9:0] m_frame[$];
    int         m_outstanding = 0;
    int         m_drop = 0;
    int         words_seen = 0;
    int         ready_mode = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_active = 0; m_stalled = 0; m_chan = '0; m_frame.delete();
        m_outstanding = 0; m_drop = 0; words_seen = 0; exp_q.delete();
    endtask

    task automatic model_step();
        word_t w;
        if (!enable) begin
            m_active = 0; m_stalled = 0; m_frame.delete();
            return;
        end
        if (!m_active) begin
            m_active = 1; m_chan = cfg_channel; m_frame.delete();
            m_stalled = (m_outstanding == 2);
            if (m_stalled) return;
        end else if (m_stalled) begin
            if (m_outstanding < 2) m_stalled = 0;
            else begin
                if (new_sample && sample_channel == m_chan && m_drop < 65535) m_drop++;
                return;
            end
        end
        if (new_sample && sample_channel == m_chan) begin
            m_frame.push_back(sample);
            if (m_frame.size() == FRAME_LEN) begin
                for (int i = 0; i < FRAME_LEN; i++) begin
                    w.data = m_frame[i]; w.last = (i == FRAME_LEN - 1); w.chan = m_chan;
                    exp_q.push_back(w);
                end
                m_frame.delete();
                m_outstanding++;
                m_chan = cfg_channel;
                if (m_outstanding == 2) m_stalled = 1;
            end
        end
    endtask

    task automatic cyc(input bit en, input bit ns, input logic [3:0] sch,
                       input logic [9:0] s, input logic [3:0] cfg);
        enable = en; new_sample = ns; sample_channel = sch; sample = s; cfg_channel = cfg;
        case (ready_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 4) != 0);
        endcase
        model_step();
        @(posedge clk); #1;
        check("adc_channel", adc_channel, m_chan);
        check("drop_count", drop_count, m_drop);
    endtask

    task automatic feed(input int n_match, input logic [3:0] ch, input logic [3:0] cfg,
                        input int min_gap, input int max_gap, input int noise_pct,
                        input logic [3:0] noise_ch);
        int got = 0;
        while (got < n_match) begin
            repeat ($urandom_range(min_gap, max_gap)) cyc(1, 0, 4'd0, 10'd0, cfg);
            if ($urandom_range(0, 99) < noise_pct)
                cyc(1, 1, noise_ch, 10'($urandom_range(0, 1023)), cfg);
            else begin
                cyc(1, 1, ch, 10'($urandom_range(0, 1023)), cfg);
                got++;
            end
        end
    endtask

    task automatic drain(input bit en, input logic [3:0] cfg);
        int budget = 4000;
        while (exp_q.size() != 0 && budget > 0) begin
            cyc(en, 0, 4'd0, 10'd0, cfg);
            budget--;
        end
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain_timeout: %0d words still pending, expected 0", exp_q.size());
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_channel"}, out_channel, 0);
        check({tag, "_drop_count"}, drop_count, 0);
        check({tag, "_adc_channel"}, adc_channel, 0);
    endtask

    // Monitor: samples on the falling edge, ahead of the handshake edge.
    initial begin
        word_t       w;
        bit          prev_stall = 0;
        logic [15:0] prev_word = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
                continue;
            end
            if (prev_stall)
                check("hold_stable", {out_valid, out_data, out_last, out_channel}, prev_word);
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_valid, out_data, out_last, out_channel};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_word: got data %0h, expected no output", out_data);
                end else begin
                    w = exp_q.pop_front();
                    check("out_data", out_data, w.data);
                    check("out_last", out_last, w.last);
                    check("out_channel", out_channel, w.chan);
                end
                words_seen++;
                if (out_last) begin
                    m_outstanding--;
                    words_seen = 0;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Test 1: ramp frame on channel 3, plus first-valid latency
        ready_mode = 1;
        for (int i = 0; i < FRAME_LEN; i++) begin
            cyc(1, 1, 4'd3, 10'(i), 4'd3);
            if (i != FRAME_LEN - 1) cyc(1, 0, 4'd0, 10'd0, 4'd3);
        end
        cyc(1, 0, 4'd0, 10'd0, 4'd3);
        check("latency_early", out_valid, 0);
        cyc(1, 0, 4'd0, 10'd0, 4'd3);
        check("latency_valid", out_valid, 1);
        drain(1, 4'd3);

        // Test 2: channel-2 samples interleaved, random backpressure
        ready_mode = 2;
        feed(FRAME_LEN, 4'd3, 4'd3, 2, 5, 35, 4'd2);
        drain(1, 4'd3);

        // Test 3: no readout while three frames arrive; third overruns
        ready_mode = 0;
        feed(3 * FRAME_LEN, 4'd3, 4'd3, 0, 0, 0, 4'd2);
        cyc(1, 0, 4'd0, 10'd0, 4'd3);
        check("overrun_drops", drop_count, m_drop);
        ready_mode = 1;
        drain(1, 4'd3);

        // Test 4: cfg_channel 3->5 mid-frame takes effect at the boundary
        ready_mode = 2;
        feed(100, 4'd3, 4'd3, 2, 4, 10, 4'd5);
        feed(FRAME_LEN - 100, 4'd3, 4'd5, 2, 4, 10, 4'd5);
        feed(FRAME_LEN, 4'd5, 4'd5, 2, 4, 20, 4'd3);
        drain(1, 4'd5);

        // Test 5: enable dropped after 50 samples, then a fresh frame
        repeat (2) cyc(0, 0, 4'd0, 10'd0, 4'd3);
        feed(50, 4'd3, 4'd3, 1, 3, 0, 4'd2);
        cyc(0, 1, 4'd3, 10'h3ff, 4'd3);
        repeat (2) cyc(0, 0, 4'd0, 10'd0, 4'd3);
        feed(FRAME_LEN, 4'd3, 4'd3, 2, 4, 10, 4'd7);
        drain(1, 4'd3);

        // Test 6: asynchronous reset at word 10 of a streaming frame
        ready_mode = 1;
        feed(FRAME_LEN, 4'd3, 4'd3, 0, 1, 0, 4'd2);
        budget = 200;
        while (words_seen < 10 && budget > 0) begin
            cyc(1, 0, 4'd0, 10'd0, 4'd3);
            budget--;
        end
        check("reach_word10", (words_seen >= 10), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("async_reset");
        repeat (3) cyc(0, 0, 4'd0, 10'd0, 4'd3);
        rst_n = 1'b1;
        feed(FRAME_LEN, 4'd3, 4'd3, 1, 3, 15, 4'd9);
        drain(1, 4'd3);
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
